inst_inject_trace: RTL and testbench
====================================

# inst_inject_trace

Debug block between instruction memory and the decoder of the single-cycle processor. It replaces hand-driven instruction words in top-level benches with a parametrised injection FIFO that overrides the fetched instruction stream. It also has a circular trace buffer that records the word-index PC, the ALU result and the injection status on every traced cycle. The same block drives directed-instruction tests in simulation and on the board.

## Interface
Parameters:
- DBITS, 32, data/PC width
- INST_BIT_WIDTH, 32, instruction word width
- INJ_DEPTH, 16, injection FIFO entries (power of 2, ≥2)
- TRACE_DEPTH, 16, trace entries (power of 2, ≥2)
- IMEM_PC_BITS_LO, 2, PC right-shift used for the traced word index

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- inst_mem  in  INST_BIT_WIDTH  word from instruction memory
- inst_out  out  INST_BIT_WIDTH  word to the decoder
- push_valid  in  1  injection word offered
- push_data  in  INST_BIT_WIDTH  injection word
- push_ready  out  1  FIFO not full
- inj_start  in  1  one-cycle pulse, begins injection
- inj_abort  in  1  flushes the FIFO and returns to pass-through
- inj_active  out  1  state is INJECT
- inj_count  out  $clog2(INJ_DEPTH)+1  FIFO occupancy
- pc_in  in  DBITS  processor PC
- alu_in  in  DBITS  processor ALU result
- trace_en  in  1  capture enable
- trace_clear  in  1  synchronous trace clear
- trace_rd_idx  in  $clog2(TRACE_DEPTH)  read index, 0 = oldest valid entry
- trace_rd_pc  out  DBITS  traced word index
- trace_rd_alu  out  DBITS  traced ALU value
- trace_rd_inj  out  1  entry was captured while inj_active
- trace_count  out  $clog2(TRACE_DEPTH)+1  valid entries, saturates at TRACE_DEPTH
- trace_wrapped  out  1  at least one entry has been overwritten

## Operation
- FSM has two states: PASS (reset state) and INJECT.
- In PASS, inst_out = inst_mem. In INJECT, inst_out = FIFO head. This mux is combinational.
- PASS→INJECT happens on a rising edge with inj_start=1, inj_count>0 and inj_abort=0. inj_start with an empty FIFO is ignored.
- In INJECT, every rising edge pops the head.
- INJECT→PASS happens on the edge that pops the last word with no push accepted on the same edge. If a push is accepted on that edge, the FSM stays in INJECT.
- inj_abort has priority over all other controls. On the edge it is seen: occupancy→0, pointers→0, state→PASS, and any push on that edge is dropped.
- push_ready = (inj_count < INJ_DEPTH), derived from registered occupancy. A push while full is rejected even if a pop occurs on the same edge.
- A push and a pop on the same edge leave occupancy unchanged. FIFO pointers wrap modulo INJ_DEPTH.
- Trace capture: on each edge with trace_en=1 and trace_clear=0, write {pc_in >> IMEM_PC_BITS_LO, alu_in, inj_active} at wr_ptr, then advance wr_ptr modulo TRACE_DEPTH.
  - trace_count increments up to TRACE_DEPTH.
  - trace_wrapped sets on the first write made while trace_count == TRACE_DEPTH.
- trace_clear takes priority over a write on the same edge. It clears wr_ptr, trace_count and trace_wrapped; entry contents are not cleared.
- Trace read is combinational. Physical address = (trace_count < TRACE_DEPTH ? 0 : wr_ptr) + trace_rd_idx, modulo TRACE_DEPTH.
  - trace_rd_idx ≥ trace_count returns the stored, stale contents. This is not an error.

## Timing
- Reset values: state PASS, inst_out = inst_mem, push_ready 1, inj_active 0, inj_count 0, trace_count 0, trace_wrapped 0, all pointers 0.
- Trace read outputs after reset are undefined until the entry is written.
- Reset asserted mid-injection forces PASS and an empty FIFO without waiting for a clock edge. Words already injected are not replayed.
- Latency:
  - inj_start at edge N makes the first injected word visible after N. It is popped at N+1.
  - K words give exactly K cycles with inj_active=1.
- A word pushed at edge N appears in inj_count and at the FIFO head after N. It can be injected from edge N+1.
- A trace write at edge N is readable after N.
- inj_active sampled into the trace equals the state during the cycle before the edge, i.e. the cycle whose instruction was executed.

## Test plan
- Pass-through: inst_mem = 32'h80860bef, no injection → inst_out = 32'h80860bef every cycle, inj_active 0.
- Injection sequence: push 80860bef, 06ddd000, 8bc0f000, 8b600000, then pulse inj_start → inst_out shows those four words on consecutive cycles. inj_active is high for exactly 4 cycles, then PASS, and inj_count reaches 0.
- Full and simultaneous: with INJ_DEPTH=16, push 17 words → 17th rejected (push_ready 0, inj_count 16). During injection, push and pop on the same edge → inj_count holds.
- Trace wrap: trace_en for 20 cycles with pc_in = 32'h40 + 4·i → trace_count 16, trace_wrapped 1. trace_rd_idx 0 gives pc 0x14; idx 15 gives 0x23.
- Abort, clear and reset mid-operation:
  - inj_abort after 2 of 5 injected words → PASS next cycle, inj_count 0.
  - trace_clear together with trace_en → trace_count 0.
  - Asynchronous reset between clock edges → every output at its reset value immediately.

Source files
------------

// File: rtl/inst_inject_trace.sv
// ----------------------------------------------------------------------------
// inst_inject_trace
//
// Debug block that sits between instruction memory and the decoder.
//   * Injection path: a FIFO of instruction words that, once started, replaces
//     the fetched word stream one word per cycle until it drains or is aborted.
//   * Trace path: a circular buffer recording {PC word index, ALU result,
//     injection status} on every cycle with trace_en set.
//
// Ports
//   clk, reset           : single clock, asynchronous active-high reset
//   inst_mem / inst_out  : fetched word in, word presented to the decoder out
//   push_valid/_data     : offer a word to the injection FIFO
//   push_ready           : FIFO not full
//   inj_start / inj_abort: begin injection / flush FIFO and return to PASS
//   inj_active           : FSM is in INJECT
//   inj_count            : FIFO occupancy
//   pc_in / alu_in       : processor PC and ALU result to be traced
//   trace_en/trace_clear : capture enable / synchronous trace clear
//   trace_rd_idx         : read index, 0 = oldest valid entry
//   trace_rd_pc/_alu/_inj: combinational read of the selected entry
//   trace_count          : valid entries, saturating at TRACE_DEPTH
//   trace_wrapped        : at least one entry has been overwritten
// ----------------------------------------------------------------------------
module inst_inject_trace #(
    parameter int DBITS           = 32,
    parameter int INST_BIT_WIDTH  = 32,
    parameter int INJ_DEPTH       = 16,
    parameter int TRACE_DEPTH     = 16,
    parameter int IMEM_PC_BITS_LO = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [INST_BIT_WIDTH-1:0]        inst_mem,
    output logic [INST_BIT_WIDTH-1:0]        inst_out,
    input  logic                             push_valid,
    input  logic [INST_BIT_WIDTH-1:0]        push_data,
    output logic                             push_ready,
    input  logic                             inj_start,
    input  logic                             inj_abort,
    output logic                             inj_active,
    output logic [$clog2(INJ_DEPTH):0]       inj_count,
    input  logic [DBITS-1:0]                 pc_in,
    input  logic [DBITS-1:0]                 alu_in,
    input  logic                             trace_en,
    input  logic                             trace_clear,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_rd_idx,
    output logic [DBITS-1:0]                 trace_rd_pc,
    output logic [DBITS-1:0]                 trace_rd_alu,
    output logic                             trace_rd_inj,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count,
    output logic                             trace_wrapped
);

    localparam int IW = $clog2(INJ_DEPTH);
    localparam int TW = $clog2(TRACE_DEPTH);

    localparam logic [0:0] ST_PASS   = 1'b0;
    localparam logic [0:0] ST_INJECT = 1'b1;

    localparam logic [IW:0] INJ_FULL = (IW+1)'(INJ_DEPTH);
    localparam logic [TW:0] TR_FULL  = (TW+1)'(TRACE_DEPTH);

    // ------------------------------------------------------------------
    // Injection FIFO and FSM
    // ------------------------------------------------------------------
    logic [INST_BIT_WIDTH-1:0] r_inj_mem [INJ_DEPTH];
    logic [IW-1:0]             r_inj_rd_ptr;
    logic [IW-1:0]             r_inj_wr_ptr;
    logic [IW:0]               r_inj_count;
    logic [0:0]                r_state;

    logic                      w_push_acc;
    logic                      w_pop;
    logic [0:0]                w_state_nxt;
    logic [IW:0]               w_inj_count_nxt;

    // Full check uses registered occupancy, so a pop on the same edge
    // cannot make room for a push; abort drops any push on its edge.
    assign w_push_acc = push_valid & (r_inj_count < INJ_FULL) & ~inj_abort;
    assign w_pop      = (r_state == ST_INJECT) & (r_inj_count != {(IW+1){1'b0}});

    // Next FSM state: abort wins, start needs a non-empty FIFO, and the
    // last pop only leaves INJECT when no new word arrives alongside it.
    always_comb begin
        w_state_nxt = r_state;
        if (inj_abort) begin
            w_state_nxt = ST_PASS;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (inj_start && (r_inj_count != {(IW+1){1'b0}})) begin
                        w_state_nxt = ST_INJECT;
                    end else begin
                        w_state_nxt = ST_PASS;
                    end
                end
                ST_INJECT: begin
                    if (w_pop && (r_inj_count == {{IW{1'b0}}, 1'b1}) && !w_push_acc) begin
                        w_state_nxt = ST_PASS;
                    end else begin
                        w_state_nxt = ST_INJECT;
                    end
                end
                default: w_state_nxt = ST_PASS;
            endcase
        end
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_inj_count_nxt = r_inj_count;
        if (inj_abort) begin
            w_inj_count_nxt = {(IW+1){1'b0}};
        end else begin
            case ({w_push_acc, w_pop})
                2'b10:   w_inj_count_nxt = r_inj_count + {{IW{1'b0}}, 1'b1};
                2'b01:   w_inj_count_nxt = r_inj_count - {{IW{1'b0}}, 1'b1};
                default: w_inj_count_nxt = r_inj_count;
            endcase
        end
    end

    // FSM state, FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_PASS;
            r_inj_rd_ptr <= {IW{1'b0}};
            r_inj_wr_ptr <= {IW{1'b0}};
            r_inj_count  <= {(IW+1){1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_inj_count <= w_inj_count_nxt;
            if (inj_abort) begin
                r_inj_rd_ptr <= {IW{1'b0}};
                r_inj_wr_ptr <= {IW{1'b0}};
            end else begin
                if (w_push_acc) begin
                    r_inj_wr_ptr <= r_inj_wr_ptr + {{(IW-1){1'b0}}, 1'b1};
                end
                if (w_pop) begin
                    r_inj_rd_ptr <= r_inj_rd_ptr + {{(IW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // FIFO storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_inj_mem[r_inj_wr_ptr] <= push_data;
        end
    end

    assign inst_out   = (r_state == ST_INJECT) ? r_inj_mem[r_inj_rd_ptr] : inst_mem;
    assign push_ready = (r_inj_count < INJ_FULL);
    assign inj_active = (r_state == ST_INJECT);
    assign inj_count  = r_inj_count;

    // ------------------------------------------------------------------
    // Trace buffer
    // ------------------------------------------------------------------
    logic [DBITS-1:0] r_tr_pc  [TRACE_DEPTH];
    logic [DBITS-1:0] r_tr_alu [TRACE_DEPTH];
    logic             r_tr_inj [TRACE_DEPTH];
    logic [TW-1:0]    r_tr_wr_ptr;
    logic [TW:0]      r_tr_count;
    logic             r_tr_wrapped;

    logic             w_tr_wr;
    logic [DBITS-1:0] w_pc_word;
    logic [TW-1:0]    w_tr_base;
    logic [TW-1:0]    w_tr_rd_addr;

    assign w_tr_wr   = trace_en & ~trace_clear;
    assign w_pc_word = pc_in >> IMEM_PC_BITS_LO;

    // Trace write pointer, occupancy and wrap flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tr_wr_ptr  <= {TW{1'b0}};
            r_tr_count   <= {(TW+1){1'b0}};
            r_tr_wrapped <= 1'b0;
        end else if (trace_clear) begin
            r_tr_wr_ptr  <= {TW{1'b0}};
            r_tr_count   <= {(TW+1){1'b0}};
            r_tr_wrapped <= 1'b0;
        end else if (w_tr_wr) begin
            r_tr_wr_ptr <= r_tr_wr_ptr + {{(TW-1){1'b0}}, 1'b1};
            if (r_tr_count < TR_FULL) begin
                r_tr_count <= r_tr_count + {{TW{1'b0}}, 1'b1};
            end else begin
                // Buffer already full: this write overwrites the oldest entry.
                r_tr_wrapped <= 1'b1;
            end
        end
    end

    // Trace storage; the injection bit is the state of the cycle just executed.
    always_ff @(posedge clk) begin
        if (w_tr_wr) begin
            r_tr_pc[r_tr_wr_ptr]  <= w_pc_word;
            r_tr_alu[r_tr_wr_ptr] <= alu_in;
            r_tr_inj[r_tr_wr_ptr] <= inj_active;
        end
    end

    // Until the buffer fills, the oldest entry sits at address 0; after that
    // it is the slot the next write will overwrite.
    assign w_tr_base    = (r_tr_count < TR_FULL) ? {TW{1'b0}} : r_tr_wr_ptr;
    assign w_tr_rd_addr = w_tr_base + trace_rd_idx;

    assign trace_rd_pc   = r_tr_pc[w_tr_rd_addr];
    assign trace_rd_alu  = r_tr_alu[w_tr_rd_addr];
    assign trace_rd_inj  = r_tr_inj[w_tr_rd_addr];
    assign trace_count   = r_tr_count;
    assign trace_wrapped = r_tr_wrapped;

endmodule

// File: tb/tb_inst_inject_trace.sv
// ----------------------------------------------------------------------------
// tb_inst_inject_trace
//
// Directed scenarios followed by randomized traffic, each cycle compared
// against a queue-based reference model of the injection FIFO and the trace.
// ----------------------------------------------------------------------------
module tb_inst_inject_trace;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_mem;
    logic [31:0] inst_out;
    logic        push_valid;
    logic [31:0] push_data;
    logic        push_ready;
    logic        inj_start;
    logic        inj_abort;
    logic        inj_active;
    logic [4:0]  inj_count;
    logic [31:0] pc_in;
    logic [31:0] alu_in;
    logic        trace_en;
    logic        trace_clear;
    logic [3:0]  trace_rd_idx;
    logic [31:0] trace_rd_pc;
    logic [31:0] trace_rd_alu;
    logic        trace_rd_inj;
    logic [4:0]  trace_count;
    logic        trace_wrapped;

    inst_inject_trace dut (
        .clk          (clk),
        .reset        (reset),
        .inst_mem     (inst_mem),
        .inst_out     (inst_out),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_ready   (push_ready),
        .inj_start    (inj_start),
        .inj_abort    (inj_abort),
        .inj_active   (inj_active),
        .inj_count    (inj_count),
        .pc_in        (pc_in),
        .alu_in       (alu_in),
        .trace_en     (trace_en),
        .trace_clear  (trace_clear),
        .trace_rd_idx (trace_rd_idx),
        .trace_rd_pc  (trace_rd_pc),
        .trace_rd_alu (trace_rd_alu),
        .trace_rd_inj (trace_rd_inj),
        .trace_count  (trace_count),
        .trace_wrapped(trace_wrapped)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic        inj;
    } tr_t;

    logic [31:0] m_q[$];
    bit          m_active;
    tr_t         m_tr[$];
    bit          m_wrapped;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_tr.delete();
        m_active  = 1'b0;
        m_wrapped = 1'b0;
    endtask

    // Apply one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit  was_active;
        bit  full;
        tr_t e;
        was_active = m_active;
        full       = (m_q.size() == DEPTH);
        if (trace_clear) begin
            m_tr.delete();
            m_wrapped = 1'b0;
        end else if (trace_en) begin
            e.pc  = pc_in / 4;
            e.alu = alu_in;
            e.inj = was_active;
            if (m_tr.size() == DEPTH) begin
                void'(m_tr.pop_front());
                m_wrapped = 1'b1;
            end
            m_tr.push_back(e);
        end
        if (inj_abort) begin
            m_q.delete();
            m_active = 1'b0;
        end else begin
            if (was_active && m_q.size() > 0) void'(m_q.pop_front());
            if (push_valid && !full) m_q.push_back(push_data);
            if (was_active && m_q.size() == 0) m_active = 1'b0;
            if (!was_active && inj_start && (full || m_q.size() > (push_valid ? 1 : 0)))
                m_active = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("inj_active", {63'd0, inj_active}, {63'd0, m_active});
        chk("inj_count", {59'd0, inj_count}, 64'(m_q.size()));
        chk("push_ready", {63'd0, push_ready}, {63'd0, (m_q.size() < DEPTH)});
        chk("inst_out", {32'd0, inst_out}, {32'd0, (m_active ? m_q[0] : inst_mem)});
        chk("trace_count", {59'd0, trace_count}, 64'(m_tr.size()));
        chk("trace_wrapped", {63'd0, trace_wrapped}, {63'd0, m_wrapped});
        if (m_tr.size() > 0) begin
            int idx;
            idx = $urandom_range(0, m_tr.size() - 1);
            trace_rd_idx = 4'(idx);
            #1;
            chk("trace_rd_pc", {32'd0, trace_rd_pc}, {32'd0, m_tr[idx].pc});
            chk("trace_rd_alu", {32'd0, trace_rd_alu}, {32'd0, m_tr[idx].alu});
            chk("trace_rd_inj", {63'd0, trace_rd_inj}, {63'd0, m_tr[idx].inj});
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        push_valid  = 1'b0;
        push_data   = 32'd0;
        inj_start   = 1'b0;
        inj_abort   = 1'b0;
        trace_en    = 1'b0;
        trace_clear = 1'b0;
        pc_in       = 32'd0;
        alu_in      = 32'd0;
    endtask

    logic [31:0] words [4];
    logic [4:0]  held;

    initial begin
        words[0] = 32'h80860bef;
        words[1] = 32'h06ddd000;
        words[2] = 32'h8bc0f000;
        words[3] = 32'h8b600000;

        // ---- reset ----
        reset        = 1'b1;
        inst_mem     = 32'h80860bef;
        trace_rd_idx = 4'd0;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_inst_out", {32'd0, inst_out}, {32'd0, 32'h80860bef});
        chk("rst_push_ready", {63'd0, push_ready}, 64'd1);
        chk("rst_inj_active", {63'd0, inj_active}, 64'd0);
        chk("rst_inj_count", {59'd0, inj_count}, 64'd0);
        chk("rst_trace_count", {59'd0, trace_count}, 64'd0);
        chk("rst_trace_wrapped", {63'd0, trace_wrapped}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---- pass-through ----
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("pass_inst_out", {32'd0, inst_out}, {32'd0, 32'h80860bef});
        end

        // ---- injection of four words ----
        inst_mem = 32'h00000013;
        for (int k = 0; k < 4; k++) begin
            push_valid = 1'b1;
            push_data  = words[k];
            cycle();
        end
        push_valid = 1'b0;
        inj_start  = 1'b1;
        cycle();
        inj_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("inj_word", {32'd0, inst_out}, {32'd0, words[k]});
            chk("inj_active_on", {63'd0, inj_active}, 64'd1);
            cycle();
        end
        chk("inj_done_active", {63'd0, inj_active}, 64'd0);
        chk("inj_done_count", {59'd0, inj_count}, 64'd0);

        // ---- full FIFO and simultaneous push/pop ----
        push_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            push_data = $urandom;
            cycle();
            if (k == 15) chk("full_ready", {63'd0, push_ready}, 64'd0);
        end
        chk("full_count", {59'd0, inj_count}, 64'd16);
        inj_start = 1'b1;
        cycle();
        inj_start = 1'b0;
        cycle();
        chk("popfull_count", {59'd0, inj_count}, 64'd15);
        held = inj_count;
        push_data = $urandom;
        cycle();
        chk("pushpop_hold", {59'd0, inj_count}, {59'd0, held});
        push_data = $urandom;
        cycle();
        chk("pushpop_hold2", {59'd0, inj_count}, {59'd0, held});
        push_valid = 1'b0;
        for (int i = 0; i < 40 && m_active; i++) cycle();
        chk("drain_active", {63'd0, inj_active}, 64'd0);

        // ---- abort after two of five words ----
        push_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_data = $urandom;
            cycle();
        end
        push_valid = 1'b0;
        inj_start  = 1'b1;
        cycle();
        inj_start = 1'b0;
        cycle();
        cycle();
        inj_abort = 1'b1;
        cycle();
        inj_abort = 1'b0;
        chk("abort_active", {63'd0, inj_active}, 64'd0);
        chk("abort_count", {59'd0, inj_count}, 64'd0);
        chk("abort_inst_out", {32'd0, inst_out}, {32'd0, inst_mem});

        // ---- trace wrap ----
        trace_clear = 1'b1;
        cycle();
        trace_clear = 1'b0;
        trace_en    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_in  = 32'h40 + 32'(4 * i);
            alu_in = $urandom;
            cycle();
        end
        trace_en = 1'b0;
        chk("wrap_count", {59'd0, trace_count}, 64'd16);
        chk("wrap_flag", {63'd0, trace_wrapped}, 64'd1);
        trace_rd_idx = 4'd0;
        #1;
        chk("wrap_idx0_pc", {32'd0, trace_rd_pc}, 64'h14);
        trace_rd_idx = 4'd15;
        #1;
        chk("wrap_idx15_pc", {32'd0, trace_rd_pc}, 64'h23);

        // ---- clear with enable ----
        trace_en    = 1'b1;
        trace_clear = 1'b1;
        cycle();
        trace_clear = 1'b0;
        trace_en    = 1'b0;
        chk("clear_count", {59'd0, trace_count}, 64'd0);
        chk("clear_wrapped", {63'd0, trace_wrapped}, 64'd0);

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            inst_mem    = $urandom;
            push_valid  = 1'($urandom_range(0, 1));
            push_data   = $urandom;
            inj_start   = ($urandom_range(0, 5) == 0);
            inj_abort   = ($urandom_range(0, 40) == 0);
            trace_en    = ($urandom_range(0, 3) != 0);
            trace_clear = ($urandom_range(0, 60) == 0);
            pc_in       = $urandom;
            alu_in      = $urandom;
            cycle();
        end

        // ---- asynchronous reset mid-injection ----
        idle_inputs();
        push_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_data = $urandom;
            cycle();
        end
        push_valid = 1'b0;
        inj_start  = 1'b1;
        trace_en   = 1'b1;
        cycle();
        inj_start = 1'b0;
        trace_en  = 1'b0;
        cycle();
        chk("pre_rst_active", {63'd0, inj_active}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_inst_out", {32'd0, inst_out}, {32'd0, inst_mem});
        chk("arst_inj_active", {63'd0, inj_active}, 64'd0);
        chk("arst_inj_count", {59'd0, inj_count}, 64'd0);
        chk("arst_push_ready", {63'd0, push_ready}, 64'd1);
        chk("arst_trace_count", {59'd0, trace_count}, 64'd0);
        chk("arst_trace_wrapped", {63'd0, trace_wrapped}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
